hazard_sequencer: RTL
=====================

Name: hazard_sequencer

Overview:
Pipeline control unit for the 5-stage RISC-V core. It drives the per-stage EN and flush inputs of the fetch, decode (register), execute, memory and writeback pipeline registers, and generates the execute-stage forwarding selects. It sequences three things: load-use stalls, branch/jump redirects with extra fetch bubbles for the synchronous instruction memory, and data-memory wait states with timeout detection. It also exposes stall and flush performance counters.

Parameters:
REDIRECT_BUBBLES, 1, extra decode-flush cycles after a redirect; legal range 0..7
MEM_TIMEOUT, 255, consecutive data-memory wait cycles before mem_timeout is set; minimum 1
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
D_R_1_num  in  5  rs1 of the instruction in decode
D_R_2_num  in  5  rs2 of the instruction in decode
E_R_1_num  in  5  rs1 held in the execute register
E_R_2_num  in  5  rs2 held in the execute register
E_DR_num  in  5  rd in execute
E_MemRead  in  1  execute instruction is a load
E_PCSrc  in  1  branch taken or jump resolved in execute
M_DR_num  in  5  rd in memory stage
M_RegWrite  in  1  memory-stage instruction writes rd
W_DR_num  in  5  rd in writeback
W_RegWrite  in  1  writeback instruction writes rd
dmem_req  in  1  memory stage is accessing data memory this cycle
dmem_ready  in  1  data memory completes the access this cycle
EN_F, EN_D, EN_E, EN_M, EN_W  out  1 each  stage-register enables
FLUSH_D, FLUSH_E, FLUSH_W  out  1 each  load a bubble (all controls 0) into that stage register
ForwardA_E, ForwardB_E  out  2 each  00 = register file, 01 = writeback result, 10 = memory-stage ALU result
mem_timeout  out  1  sticky error flag
stall_cycles  out  CNT_W  count of cycles with EN_F = 0
flush_count  out  CNT_W  count of accepted redirects

Behaviour:
- Reset: state RUN, redirect counter 0, wait counter 0, mem_timeout 0, both performance counters 0. Reset has priority over every other event, including reset during a wait or redirect.
- Outputs are combinational from the current state and inputs. Defaults: all EN = 1, all FLUSH = 0.
- Forwarding (pure combinational):
  - ForwardA_E = 10 when M_RegWrite, M_DR_num != 0 and M_DR_num == E_R_1_num.
  - Otherwise ForwardA_E = 01 when W_RegWrite, W_DR_num != 0 and W_DR_num == E_R_1_num.
  - Otherwise ForwardA_E = 00. ForwardB_E is the same rule using E_R_2_num.
- mem_busy = dmem_req & ~dmem_ready. Per-cycle priority: mem_busy > redirect > load-use.
- mem_busy (any state):
  - EN_F = EN_D = EN_E = EN_M = 0, FLUSH_W = 1.
  - Redirect counter and state are frozen. The wait counter increments, saturating at MEM_TIMEOUT.
  - When the wait counter reaches MEM_TIMEOUT, mem_timeout is set and stays set until reset. The pipeline keeps waiting.
  - The wait counter clears on any cycle without mem_busy.
- RUN, E_PCSrc = 1 (and not mem_busy):
  - FLUSH_D = FLUSH_E = 1, all EN = 1, flush_count increments.
  - If REDIRECT_BUBBLES > 0, go to REDIRECT with the counter set to REDIRECT_BUBBLES. Otherwise stay in RUN.
- RUN, load-use (and no mem_busy, no E_PCSrc):
  - Condition: E_MemRead, E_DR_num != 0, and E_DR_num equals D_R_1_num or D_R_2_num.
  - EN_F = EN_D = 0, FLUSH_E = 1. Exactly one stall cycle, because the load then advances to the memory stage.
- REDIRECT (not mem_busy):
  - FLUSH_D = 1, all EN = 1. Load-use detection is suppressed because decode holds a squashed instruction.
  - The counter decrements; return to RUN after the cycle in which the counter equals 1.
  - E_PCSrc cannot be 1 in this state because the execute stage holds a bubble. If it is asserted anyway, treat it as a new redirect: reload the counter and increment flush_count.
- stall_cycles increments on every cycle with EN_F = 0, including memory waits and load-use stalls.
- Both counters wrap modulo 2^CNT_W.

Test Plan:
- Forwarding priority: M_RegWrite = 1, M_DR_num = 5; W_RegWrite = 1, W_DR_num = 5; E_R_1_num = 5 -> ForwardA_E = 10. Then M_RegWrite = 0 -> 01. Then all rd = 0 -> 00.
- Load-use: E_MemRead = 1, E_DR_num = 7, D_R_2_num = 7 -> exactly one cycle of EN_F = EN_D = 0, FLUSH_E = 1, stall_cycles = 1. With E_DR_num = 0 -> no stall.
- Redirect, REDIRECT_BUBBLES = 2: pulse E_PCSrc -> FLUSH_D = FLUSH_E = 1 in cycle 0; FLUSH_D = 1 only in cycles 1 and 2; RUN in cycle 3; flush_count = 1. A load-use match during cycles 1-2 is ignored.
- Memory wait: dmem_req = 1, dmem_ready = 0 for 3 cycles, then ready -> EN_F..EN_M = 0 and FLUSH_W = 1 for 3 cycles, all EN = 1 on the ready cycle, stall_cycles = 3.
- Wait during redirect: assert mem_busy in redirect cycle 1 for 2 cycles -> redirect counter frozen; FLUSH_D resumes for the remaining bubbles once ready.
- Timeout and reset: MEM_TIMEOUT = 4, hold mem_busy 6 cycles -> mem_timeout rises after the 4th wait cycle and stays high. Assert reset mid-wait -> next cycle mem_timeout = 0, counters = 0, state RUN.

Source files
------------

// File: rtl/hazard_sequencer_if.sv
// Pipeline-control bundle between the 5-stage datapath (master) and the hazard sequencer (slave).
// Carries hazard-detection inputs, stage enables/flushes, forwarding selects and perf counters.
interface hazard_sequencer_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       D_R_1_num;
  logic [4:0]       D_R_2_num;
  logic [4:0]       E_R_1_num;
  logic [4:0]       E_R_2_num;
  logic [4:0]       E_DR_num;
  logic             E_MemRead;
  logic             E_PCSrc;
  logic [4:0]       M_DR_num;
  logic             M_RegWrite;
  logic [4:0]       W_DR_num;
  logic             W_RegWrite;
  logic             dmem_req;
  logic             dmem_ready;

  logic             EN_F;
  logic             EN_D;
  logic             EN_E;
  logic             EN_M;
  logic             EN_W;
  logic             FLUSH_D;
  logic             FLUSH_E;
  logic             FLUSH_W;
  logic [1:0]       ForwardA_E;
  logic [1:0]       ForwardB_E;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output D_R_1_num, D_R_2_num, E_R_1_num, E_R_2_num, E_DR_num, E_MemRead, E_PCSrc,
           M_DR_num, M_RegWrite, W_DR_num, W_RegWrite, dmem_req, dmem_ready,
    input  EN_F, EN_D, EN_E, EN_M, EN_W, FLUSH_D, FLUSH_E, FLUSH_W,
           ForwardA_E, ForwardB_E, mem_timeout, stall_cycles, flush_count
  );

  modport slave (
    input  D_R_1_num, D_R_2_num, E_R_1_num, E_R_2_num, E_DR_num, E_MemRead, E_PCSrc,
           M_DR_num, M_RegWrite, W_DR_num, W_RegWrite, dmem_req, dmem_ready,
    output EN_F, EN_D, EN_E, EN_M, EN_W, FLUSH_D, FLUSH_E, FLUSH_W,
           ForwardA_E, ForwardB_E, mem_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_sequencer.sv
// Pipeline control for the 5-stage core: load-use stalls, redirect bubbles, dmem wait states.
// Enables/flushes/forwarding are combinational (0 latency); a dmem wait freezes F..M and bubbles W.
module hazard_sequencer #(
  parameter int REDIRECT_BUBBLES = 1,
  parameter int MEM_TIMEOUT      = 255,
  parameter int CNT_W            = 32
) (
  input logic               clk,
  input logic               reset,
  hazard_sequencer_if.slave bus
);

  localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
  localparam logic [2:0]        BUBBLES  = 3'(REDIRECT_BUBBLES);

  typedef enum logic {
    S_RUN,
    S_REDIRECT
  } state_t;

  state_t            r_state;
  logic [2:0]        r_cnt;
  logic [WAIT_W-1:0] r_wait;
  logic              r_timeout;
  logic [CNT_W-1:0]  r_stall;
  logic [CNT_W-1:0]  r_flush;

  state_t            w_state_nxt;
  logic [2:0]        w_cnt_nxt;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic              w_mem_busy;
  logic              w_load_use;
  logic              w_redirect;
  logic              w_en_f, w_en_d, w_en_e, w_en_m, w_en_w;
  logic              w_flush_d, w_flush_e, w_flush_w;

  // rd of x0 never forwards; the memory stage is younger and wins over writeback.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       m_we,
    input logic [4:0] m_rd,
    input logic       w_we,
    input logic [4:0] w_rd
  );
    if (m_we && (m_rd != 5'd0) && (m_rd == rs)) return 2'b10;
    if (w_we && (w_rd != 5'd0) && (w_rd == rs)) return 2'b01;
    return 2'b00;
  endfunction

  assign bus.ForwardA_E = fwd_sel(bus.E_R_1_num, bus.M_RegWrite, bus.M_DR_num,
                                  bus.W_RegWrite, bus.W_DR_num);
  assign bus.ForwardB_E = fwd_sel(bus.E_R_2_num, bus.M_RegWrite, bus.M_DR_num,
                                  bus.W_RegWrite, bus.W_DR_num);

  assign w_mem_busy = bus.dmem_req & ~bus.dmem_ready;
  assign w_load_use = bus.E_MemRead && (bus.E_DR_num != 5'd0) &&
                      ((bus.E_DR_num == bus.D_R_1_num) || (bus.E_DR_num == bus.D_R_2_num));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_redirect  = 1'b0;
    w_en_f      = 1'b1;
    w_en_d      = 1'b1;
    w_en_e      = 1'b1;
    w_en_m      = 1'b1;
    w_en_w      = 1'b1;
    w_flush_d   = 1'b0;
    w_flush_e   = 1'b0;
    w_flush_w   = 1'b0;

    if (w_mem_busy) begin
      w_en_f    = 1'b0;
      w_en_d    = 1'b0;
      w_en_e    = 1'b0;
      w_en_m    = 1'b0;
      w_flush_w = 1'b1;
    end else if (bus.E_PCSrc) begin
      // A redirect seen while already redirecting simply restarts the bubble count.
      w_flush_d  = 1'b1;
      w_flush_e  = 1'b1;
      w_redirect = 1'b1;
      if (BUBBLES != 3'd0) begin
        w_state_nxt = S_REDIRECT;
        w_cnt_nxt   = BUBBLES;
      end else begin
        w_state_nxt = S_RUN;
      end
    end else if (r_state == S_REDIRECT) begin
      w_flush_d = 1'b1;
      w_cnt_nxt = r_cnt - 3'd1;
      if (r_cnt <= 3'd1) w_state_nxt = S_RUN;
    end else if (w_load_use) begin
      w_en_f    = 1'b0;
      w_en_d    = 1'b0;
      w_flush_e = 1'b1;
    end
  end

  always_comb begin
    w_wait_nxt = '0;
    if (w_mem_busy) w_wait_nxt = (r_wait == WAIT_MAX) ? r_wait : r_wait + WAIT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_RUN;
      r_cnt     <= '0;
      r_wait    <= '0;
      r_timeout <= 1'b0;
      r_stall   <= '0;
      r_flush   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wait  <= w_wait_nxt;
      if (w_mem_busy && (w_wait_nxt == WAIT_MAX)) r_timeout <= 1'b1;
      if (!w_en_f) r_stall <= r_stall + CNT_W'(1);
      if (w_redirect) r_flush <= r_flush + CNT_W'(1);
    end
  end

  assign bus.EN_F         = w_en_f;
  assign bus.EN_D         = w_en_d;
  assign bus.EN_E         = w_en_e;
  assign bus.EN_M         = w_en_m;
  assign bus.EN_W         = w_en_w;
  assign bus.FLUSH_D      = w_flush_d;
  assign bus.FLUSH_E      = w_flush_e;
  assign bus.FLUSH_W      = w_flush_w;
  assign bus.mem_timeout  = r_timeout;
  assign bus.stall_cycles = r_stall;
  assign bus.flush_count  = r_flush;

endmodule
